oric_ram_bridge: RTL and testbench
==================================

# oric_ram_bridge

Converts the Oric core's level-style RAM strobes (`ram_cs`/`ram_oe`/`ram_we`, 16-bit byte address) into toggle-handshake requests on one 16-bit SDRAM controller port, and returns read bytes to the core. It sits between `oricatmos` and `sdram` port1, in the 72 MHz SDRAM clock domain. It adds a one-deep pending slot, byte-lane selection, read-data capture and an ack watchdog, so no core access is lost while a previous access is still in flight.

## Interface

Parameters:
- `ACK_TIMEOUT`, default 63: cycles in WAIT_ACK before the watchdog abandons a request (legal range 8..255).

Ports:
- `clk_sys` in 1: 72 MHz SDRAM clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `ram_cs` in 1: core chip select.
- `ram_oe` in 1: core read strobe.
- `ram_we` in 1: core write strobe.
- `ram_ad` in 16: core byte address.
- `ram_d` in 8: core write data.
- `ram_q` out 8: last read byte, registered.
- `port_req` out 1: request toggle to SDRAM.
- `port_ack` in 1: ack toggle from SDRAM; a request is complete when `port_ack == port_req`.
- `port_a` out 16: latched byte address.
- `port_we` out 1: latched write flag.
- `port_ds` out 2: byte enables.
- `port_d` out 16: `{d,d}` of the latched byte.
- `port_q` in 16: SDRAM read word.
- `busy` out 1: high in WAIT_ACK or while pending is valid.
- `timeout_err` out 1: sticky, set by the watchdog.

## Operation

Registered history (all reset to 0):
- `rd_old = cs&oe`
- `wr_old = cs&we`
- `ad_old = ram_ad`

Trigger, evaluated each cycle. It fires on any of:
- `cs&oe&~rd_old`
- `cs&we&~wr_old`
- `cs&oe&(ram_ad!=ad_old)`

When a trigger fires, the access is captured as: `ram_ad`; `we = ram_we`; `ds = we ? (ad[0] ? 2'b10 : 2'b01) : 2'b11`; `d = ram_d`.

State machine:
- IDLE: on a trigger, load the `port_*` outputs from the captured access, toggle `port_req`, clear the timer, go to WAIT_ACK.
- WAIT_ACK:
  - If `port_ack == port_req`: complete the access. For a read, `ram_q <= port_a[0] ? port_q[15:8] : port_q[7:0]`.
  - After completion, if pending is valid: issue it in the same cycle (load outputs, toggle `port_req`, clear pending, clear the timer, stay in WAIT_ACK). Otherwise go to IDLE.
  - Else if timer == `ACK_TIMEOUT`: set `timeout_err`, drop pending, go to IDLE.
  - Else increment the timer (8-bit, saturating).
- Trigger while in WAIT_ACK: the access is stored in the pending slot. If pending is already valid, it is overwritten (latest wins). A pending write is never overwritten by a read; that read trigger is discarded instead.
- Trigger in the same cycle as completion: the completing access is retired first. The new trigger then issues directly if pending was empty; otherwise it goes into pending under the rules above.
- `ram_q` holds its value across writes and until the next read completes. Gating `ram_q` by `cs` is done outside this block.
- A late ack after a timeout is harmless. Equality already holds once it arrives, and the next request toggles `port_req` normally.
- Reset mid-transfer: all outputs and state return to reset values immediately. The SDRAM side is expected to be reset by the same source.

## Timing

Reset values:
- `port_req`=0, `port_we`=0, `port_a`=0, `port_ds`=2'b11, `port_d`=0
- `ram_q`=0, `busy`=0, `timeout_err`=0
- state=IDLE, pending invalid

Latency:
- Trigger sampled at edge N: `port_req` toggles and `port_a`/`port_we`/`port_ds`/`port_d` are valid after edge N (visible in cycle N+1).
- `port_*` outputs are stable for the whole of WAIT_ACK.
- Ack equality observed at edge M: `ram_q` is updated after edge M.
- Back-to-back issue from pending: the next toggle also happens at edge M, so there is zero idle cycles.

Other rules:
- `busy` is combinational from state and pending valid.
- `port_ack` is synchronous to `clk_sys` and is not resynchronised.

## Test plan

- Read: `cs=oe=1`, `ad=0x1235`, SDRAM acks after 5 cycles with `port_q=0xAB12` -> exactly one `port_req` toggle, `ds=11`, `ram_q=0xAB` after the ack edge, then IDLE with `busy=0`.
- Write: `cs=we=1`, `ad=0x0400`, `d=0x5A` -> `port_we=1`, `ds=01`, `port_d=0x5A5A`; `ram_q` unchanged after the ack.
- Address walk with `cs&oe` held, `ad` 0x0010→0x0011→0x0012 each held 1 cycle, ack delay 6 -> 0x0010 issued, 0x0012 pending, 0x0011 discarded; total of 2 toggles.
- Pending write protection: a write to 0x2000 is pending, then a read trigger at 0x3000 -> the write issues after the current ack and the read is dropped.
- Watchdog with `ACK_TIMEOUT=8` and no ack -> `timeout_err=1` after 9 WAIT_ACK cycles, state IDLE; the next trigger toggles `port_req` back to equality with `port_ack`.
- Assert `reset` during WAIT_ACK -> every output is at its reset value within the same cycle, and no toggle occurs after release until a new trigger.

Source files
------------

// File: rtl/oric_ram_bridge_if.sv
// SDRAM controller port (toggle handshake) between the bridge and sdram port1.
interface oric_ram_bridge_if;
  logic        port_req;
  logic        port_ack;
  logic [15:0] port_a;
  logic        port_we;
  logic [1:0]  port_ds;
  logic [15:0] port_d;
  logic [15:0] port_q;

  modport master (
    output port_req, port_a, port_we, port_ds, port_d,
    input  port_ack, port_q
  );

  modport slave (
    input  port_req, port_a, port_we, port_ds, port_d,
    output port_ack, port_q
  );
endinterface

// File: rtl/oric_ram_bridge.sv
// Oric core RAM strobes -> SDRAM toggle-handshake bridge with a one-deep
// pending slot, byte-lane selection, read-data capture and ack watchdog.
module oric_ram_bridge #(
  parameter int unsigned ACK_TIMEOUT = 63
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      ram_cs,
  input  logic                      ram_oe,
  input  logic                      ram_we,
  input  logic [15:0]               ram_ad,
  input  logic [7:0]                ram_d,
  output logic [7:0]                ram_q,
  oric_ram_bridge_if.master         sdram,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  typedef struct packed {
    logic [15:0] a;
    logic        we;
    logic [1:0]  ds;
    logic [7:0]  d;
  } acc_t;

  localparam acc_t ACC_RST = '{a: '0, we: 1'b0, ds: 2'b11, d: '0};

  state_t      state, state_n;
  acc_t        cur, cur_n;
  acc_t        pend, pend_n;
  logic        pend_valid, pend_valid_n;
  logic        req, req_n;
  logic [7:0]  timer, timer_n;
  logic [7:0]  q, q_n;
  logic        err, err_n;
  logic        rd_old, wr_old;
  logic [15:0] ad_old;

  logic        rd, wr, trig;
  acc_t        cap;

  assign rd   = ram_cs & ram_oe;
  assign wr   = ram_cs & ram_we;
  assign trig = (rd & ~rd_old) | (wr & ~wr_old) | (rd & (ram_ad != ad_old));

  assign cap.a  = ram_ad;
  assign cap.we = ram_we;
  assign cap.ds = ram_we ? (ram_ad[0] ? 2'b10 : 2'b01) : 2'b11;
  assign cap.d  = ram_d;

  assign sdram.port_req = req;
  assign sdram.port_a   = cur.a;
  assign sdram.port_we  = cur.we;
  assign sdram.port_ds  = cur.ds;
  assign sdram.port_d   = {cur.d, cur.d};
  assign ram_q          = q;
  assign timeout_err    = err;
  assign busy           = (state == WAIT_ACK) | pend_valid;

  // Strobe history used for edge/address-change trigger detection.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rd_old <= 1'b0;
      wr_old <= 1'b0;
      ad_old <= '0;
    end else begin
      rd_old <= rd;
      wr_old <= wr;
      ad_old <= ram_ad;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= ACC_RST;
      pend       <= '0;
      pend_valid <= 1'b0;
      req        <= 1'b0;
      timer      <= '0;
      q          <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      cur        <= cur_n;
      pend       <= pend_n;
      pend_valid <= pend_valid_n;
      req        <= req_n;
      timer      <= timer_n;
      q          <= q_n;
      err        <= err_n;
    end
  end

  // Next-state: issue, completion, pending-slot management and watchdog.
  always_comb begin
    state_n      = state;
    cur_n        = cur;
    pend_n       = pend;
    pend_valid_n = pend_valid;
    req_n        = req;
    timer_n      = timer;
    q_n          = q;
    err_n        = err;
    unique case (state)
      IDLE: begin
        if (trig) begin
          cur_n   = cap;
          req_n   = ~req;
          timer_n = '0;
          state_n = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram.port_ack == req) begin
          if (!cur.we)
            q_n = cur.a[0] ? sdram.port_q[15:8] : sdram.port_q[7:0];
          // Retire first; a queued access goes out on this same edge and the
          // slot it vacates can take a trigger arriving in this cycle.
          if (pend_valid) begin
            cur_n        = pend;
            req_n        = ~req;
            timer_n      = '0;
            pend_valid_n = trig;
            if (trig)
              pend_n = cap;
          end else if (trig) begin
            cur_n   = cap;
            req_n   = ~req;
            timer_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else if (timer == TMO) begin
          err_n        = 1'b1;
          pend_valid_n = 1'b0;
          state_n      = IDLE;
        end else begin
          if (timer != 8'hFF)
            timer_n = timer + 8'd1;
          // A queued write must survive; a read trigger yields to it.
          if (trig && !(pend_valid && pend.we && !cap.we)) begin
            pend_n       = cap;
            pend_valid_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_oric_ram_bridge.sv
// Randomized bench for oric_ram_bridge against a transaction-level model.
module tb_oric_ram_bridge;

  localparam int unsigned TMO = 8;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ram_cs, ram_oe, ram_we;
  logic [15:0] ram_ad;
  logic [7:0]  ram_d;
  logic [7:0]  ram_q;
  logic        busy, timeout_err;

  oric_ram_bridge_if bus ();

  oric_ram_bridge #(.ACK_TIMEOUT(TMO)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ram_cs      (ram_cs),
    .ram_oe      (ram_oe),
    .ram_we      (ram_we),
    .ram_ad      (ram_ad),
    .ram_d       (ram_d),
    .ram_q       (ram_q),
    .sdram       (bus.master),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic [15:0] a;
    logic        we;
    logic [7:0]  d;
  } acc_t;

  acc_t        m_cur;
  acc_t        m_pend[$];
  bit          m_active;
  bit          m_req;
  int unsigned m_age;
  logic [7:0]  m_q;
  bit          m_err;
  bit          m_rd_old, m_wr_old;
  logic [15:0] m_ad_old;

  function automatic logic [1:0] lanes(input acc_t x);
    if (!x.we) return 2'b11;
    return x.a[0] ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    m_cur    = '{a: 16'h0, we: 1'b0, d: 8'h0};
    m_pend.delete();
    m_active = 0;
    m_req    = 0;
    m_age    = 0;
    m_q      = 8'h0;
    m_err    = 0;
    m_rd_old = 0;
    m_wr_old = 0;
    m_ad_old = 16'h0;
  endtask

  task automatic model_issue(input acc_t x);
    m_cur    = x;
    m_req    = !m_req;
    m_active = 1;
    m_age    = 0;
  endtask

  // One clock edge worth of behaviour given inputs, ack and read word.
  task automatic model_step(input bit ack, input logic [15:0] word);
    bit   rd, wr, trig, done, expired, issued;
    acc_t x;
    rd   = ram_cs && ram_oe;
    wr   = ram_cs && ram_we;
    trig = (rd && !m_rd_old) || (wr && !m_wr_old) || (rd && ram_ad != m_ad_old);
    x    = '{a: ram_ad, we: ram_we, d: ram_d};
    m_rd_old = rd;
    m_wr_old = wr;
    m_ad_old = ram_ad;
    issued  = 0;
    done    = m_active && (ack == m_req);
    expired = m_active && !done && (m_age == TMO);
    if (done) begin
      if (!m_cur.we) m_q = m_cur.a[0] ? word[15:8] : word[7:0];
      m_active = 0;
      if (m_pend.size() != 0) begin
        model_issue(m_pend.pop_front());
        issued = 1;
      end
    end
    if (expired) begin
      m_err    = 1;
      m_active = 0;
      m_pend.delete();
      trig     = 0;
    end
    if (trig) begin
      if (!m_active) begin
        model_issue(x);
        issued = 1;
      end else if (!(m_pend.size() != 0 && m_pend[0].we && !x.we)) begin
        m_pend.delete();
        m_pend.push_back(x);
      end
    end
    if (m_active && !issued && m_age < 255) m_age++;
  endtask

  task automatic compare_all();
    check("port_req", 32'(bus.port_req), 32'(m_req));
    check("port_a",   32'(bus.port_a),   32'(m_cur.a));
    check("port_we",  32'(bus.port_we),  32'(m_cur.we));
    check("port_ds",  32'(bus.port_ds),  32'(lanes(m_cur)));
    check("port_d",   32'(bus.port_d),   32'({m_cur.d, m_cur.d}));
    check("ram_q",    32'(ram_q),        32'(m_q));
    check("busy",     32'(busy),         32'(m_active || m_pend.size() != 0));
    check("timeout",  32'(timeout_err),  32'(m_err));
  endtask

  // ---------------- SDRAM responder ----------------
  bit          s_counting;
  int unsigned s_cnt;

  task automatic sdram_step();
    if (bus.port_req != bus.port_ack) begin
      if (!s_counting) begin
        s_counting = 1;
        case ($urandom_range(9))
          0:       s_cnt = 12;
          1:       s_cnt = 40;
          default: s_cnt = $urandom_range(6, 1);
        endcase
      end
      s_cnt--;
      if (s_cnt == 0) begin
        bus.port_ack = bus.port_req;
        bus.port_q   = 16'($urandom);
        s_counting   = 0;
      end
    end else begin
      s_counting = 0;
    end
  endtask

  task automatic randomize_inputs();
    int unsigned r;
    r = $urandom_range(7);
    if (r == 0) begin
      ram_cs = ($urandom_range(4) != 0);
      case ($urandom_range(2))
        0:       begin ram_oe = 1'b1; ram_we = 1'b0; end
        1:       begin ram_oe = 1'b0; ram_we = 1'b1; end
        default: begin ram_oe = 1'b0; ram_we = 1'b0; end
      endcase
      ram_ad = {8'($urandom_range(3) * 32), 8'($urandom_range(7))};
      ram_d  = 8'($urandom);
    end else if (r == 1) begin
      ram_ad = ram_ad + 16'd1;
    end
  endtask

  initial begin
    reset  = 1'b1;
    ram_cs = 1'b0; ram_oe = 1'b0; ram_we = 1'b0;
    ram_ad = 16'h0; ram_d = 8'h0;
    bus.port_ack = 1'b0;
    bus.port_q   = 16'h0;
    s_counting   = 0;
    s_cnt        = 0;
    model_reset();
    repeat (2) @(negedge clk_sys);
    compare_all();
    reset = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk_sys);
      compare_all();
      reset = 1'b0;
      sdram_step();
      randomize_inputs();
      if (cyc % 997 == 500 && m_active) begin
        // asynchronous reset asserted mid-cycle while a request is in flight
        #2 reset = 1'b1;
        #1;
        model_reset();
        bus.port_ack = 1'b0;
        s_counting   = 0;
        compare_all();
      end else begin
        model_step(bus.port_ack, bus.port_q);
      end
    end

    @(negedge clk_sys);
    compare_all();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
